alu_decoder: RTL and testbench

//   Registered opcode decoder in the ALU control path. It turns a 4-bit ALU

---
 rtl/alu_decoder.sv | 99 +++++++++
 tb/tb_alu_decoder.sv | 202 ++++++++++++++++++++
 2 files changed

// File: rtl/alu_decoder.sv
// -----------------------------------------------------------------------------
// alu_decoder
//   Registered opcode decoder for the ALU control path. Each rising clk edge
//   samples a 4-bit opcode. Its one-hot function-select strobe appears on the
//   outputs one cycle later. Opcodes with no function assigned raise
//   `illegal` in place of a select.
//
// Ports
//   clk     in   1  system clock, rising-edge active
//   rst_n   in   1  asynchronous active-low reset; clears every output
//   op      in   4  ALU opcode, sampled every rising edge
//   neg     out  1  two's-complement negate   (op 0)
//   andl    out  1  bitwise AND               (op 1)
//   equ     out  1  equality test             (op 2)
//   orl     out  1  bitwise OR                (op 3)
//   dec     out  1  decrement                 (op 4)
//   add     out  1  add                       (op 5)
//   sub     out  1  subtract                  (op 6)
//   inc     out  1  increment                 (op 7)
//   cmp     out  1  magnitude compare         (op 8)
//   muls    out  1  signed multiply           (op 9)
//   illegal out  1  op 10..15 or any unknown bit in op
// -----------------------------------------------------------------------------
module alu_decoder (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] op,
  output logic       neg,
  output logic       andl,
  output logic       equ,
  output logic       orl,
  output logic       dec,
  output logic       add,
  output logic       sub,
  output logic       inc,
  output logic       cmp,
  output logic       muls,
  output logic       illegal
);

  // Bit order of the select vector: bit k is the select for opcode k.
  // Bit 10 is the illegal flag.
  localparam logic [10:0] SEL_NEG  = 11'b000_0000_0001;
  localparam logic [10:0] SEL_ANDL = 11'b000_0000_0010;
  localparam logic [10:0] SEL_EQU  = 11'b000_0000_0100;
  localparam logic [10:0] SEL_ORL  = 11'b000_0000_1000;
  localparam logic [10:0] SEL_DEC  = 11'b000_0001_0000;
  localparam logic [10:0] SEL_ADD  = 11'b000_0010_0000;
  localparam logic [10:0] SEL_SUB  = 11'b000_0100_0000;
  localparam logic [10:0] SEL_INC  = 11'b000_1000_0000;
  localparam logic [10:0] SEL_CMP  = 11'b001_0000_0000;
  localparam logic [10:0] SEL_MULS = 11'b010_0000_0000;
  localparam logic [10:0] SEL_ILL  = 11'b100_0000_0000;

  logic [10:0] sel_d;
  logic [10:0] sel_q;

  // The case items match exactly, so an opcode with an X or Z bit matches no
  // item. It falls to the default and decodes as illegal, and no select goes X.
  always_comb begin
    sel_d = SEL_ILL;
    case (op)
      4'h0:    sel_d = SEL_NEG;
      4'h1:    sel_d = SEL_ANDL;
      4'h2:    sel_d = SEL_EQU;
      4'h3:    sel_d = SEL_ORL;
      4'h4:    sel_d = SEL_DEC;
      4'h5:    sel_d = SEL_ADD;
      4'h6:    sel_d = SEL_SUB;
      4'h7:    sel_d = SEL_INC;
      4'h8:    sel_d = SEL_CMP;
      4'h9:    sel_d = SEL_MULS;
      default: sel_d = SEL_ILL;
    endcase
  end

  // During reset every output is low, including illegal. That is the only
  // time the vector is not one-hot.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sel_q <= '0;
    end else begin
      sel_q <= sel_d;
    end
  end

  assign neg     = sel_q[0];
  assign andl    = sel_q[1];
  assign equ     = sel_q[2];
  assign orl     = sel_q[3];
  assign dec     = sel_q[4];
  assign add     = sel_q[5];
  assign sub     = sel_q[6];
  assign inc     = sel_q[7];
  assign cmp     = sel_q[8];
  assign muls    = sel_q[9];
  assign illegal = sel_q[10];

endmodule

// File: tb/tb_alu_decoder.sv
// -----------------------------------------------------------------------------
// tb_alu_decoder
//   Scoreboard bench for alu_decoder. The driver pushes the expected output
//   vector together with the cycle in which it must appear. A monitor on the
//   falling edge pops and compares each entry once it is due, and checks the
//   one-hot invariant once the first post-reset edge has passed.
//   Vector order: {illegal, muls, cmp, inc, sub, add, dec, orl, equ, andl, neg}
// -----------------------------------------------------------------------------
module tb_alu_decoder;

  logic       clk;
  logic       rst_n;
  logic [3:0] op;
  logic neg, andl, equ, orl, dec, add, sub, inc, cmp, muls, illegal;

  alu_decoder dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .op      (op),
    .neg     (neg),
    .andl    (andl),
    .equ     (equ),
    .orl     (orl),
    .dec     (dec),
    .add     (add),
    .sub     (sub),
    .inc     (inc),
    .cmp     (cmp),
    .muls    (muls),
    .illegal (illegal)
  );

  logic [10:0] outs;
  assign outs = {illegal, muls, cmp, inc, sub, add, dec, orl, equ, andl, neg};

  // Expected output for each opcode, written out by hand.
  logic [10:0] exp_tab [16];
  initial begin
    exp_tab[0]  = 11'b000_0000_0001; // neg
    exp_tab[1]  = 11'b000_0000_0010; // andl
    exp_tab[2]  = 11'b000_0000_0100; // equ
    exp_tab[3]  = 11'b000_0000_1000; // orl
    exp_tab[4]  = 11'b000_0001_0000; // dec
    exp_tab[5]  = 11'b000_0010_0000; // add
    exp_tab[6]  = 11'b000_0100_0000; // sub
    exp_tab[7]  = 11'b000_1000_0000; // inc
    exp_tab[8]  = 11'b001_0000_0000; // cmp
    exp_tab[9]  = 11'b010_0000_0000; // muls
    exp_tab[10] = 11'b100_0000_0000; // illegal
    exp_tab[11] = 11'b100_0000_0000;
    exp_tab[12] = 11'b100_0000_0000;
    exp_tab[13] = 11'b100_0000_0000;
    exp_tab[14] = 11'b100_0000_0000;
    exp_tab[15] = 11'b100_0000_0000;
  end

  typedef struct {
    logic [10:0] exp;
    logic [3:0]  op;
    int          due;
  } item_t;

  item_t q[$];
  int    cyc;
  int    arm_cyc;
  int    tests;
  int    fails;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [10:0] act, input logic [10:0] req);
    tests++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s: got %b, expected %b (cycle %0d)", name, act, req, cyc);
    end
  endtask

  // Monitor: one-hot invariant plus scoreboard pops.
  always @(negedge clk) begin
    if (rst_n === 1'b1 && cyc > arm_cyc) begin
      tests++;
      if ($countones(outs) != 1 || $isunknown(outs)) begin
        fails++;
        $display("FAIL onehot: outputs %b, expected exactly one bit set (cycle %0d)", outs, cyc);
      end
    end
    while (q.size() > 0 && q[0].due <= cyc) begin
      item_t it;
      it = q.pop_front();
      check($sformatf("decode op=%b", it.op), outs, it.exp);
    end
  end

  // On a 2-state simulator an x in op collapses to a known value. The
  // expectation then follows the value the decoder actually sees.
  task automatic issue(input logic [3:0] v);
    item_t it;
    @(posedge clk);
    #1;
    op = v;
    it.op  = v;
    it.exp = $isunknown(v) ? 11'b100_0000_0000 : exp_tab[v];
    it.due = cyc + 1;
    q.push_back(it);
  endtask

  task automatic drain();
    for (int i = 0; i < 20 && q.size() > 0; i++) @(posedge clk);
    @(negedge clk);
    tests++;
    if (q.size() != 0) begin
      fails++;
      $display("FAIL drain: %0d entries still pending, expected 0", q.size());
      q.delete();
    end
  endtask

  // Release reset mid-cycle with op = 5. The first edge afterwards must
  // decode add.
  task automatic release_reset();
    item_t it;
    #2;
    rst_n = 1'b1;
    #1;
    check("released_before_edge", outs, 11'b0);
    it.op  = op;
    it.exp = exp_tab[5];
    it.due = cyc + 1;
    q.push_back(it);
    arm_cyc = cyc;
  endtask

  initial begin
    logic [3:0] xop;
    logic [3:0] r;
    cyc     = 0;
    tests   = 0;
    fails   = 0;
    arm_cyc = 1 << 30;
    rst_n   = 1'b0;
    op      = 4'h5;

    #1;
    check("reset_immediate", outs, 11'b0);
    @(posedge clk);
    @(posedge clk);
    #1;
    check("reset_held", outs, 11'b0);
    release_reset();

    // Full sweep, one opcode per cycle.
    for (int i = 0; i < 16; i++) issue(4'(i));

    // Latency: muls for exactly one cycle, then neg.
    issue(4'h9);
    issue(4'h0);
    // Boundary 9 -> A -> 9.
    issue(4'h9);
    issue(4'hA);
    issue(4'h9);
    // Unknown bit in op.
    xop = 4'b1x00;
    issue(xop);
    issue(4'h3);
    drain();

    // Mid-stream reset with op = 5.
    @(posedge clk);
    #1;
    op = 4'h5;
    #1;
    rst_n   = 1'b0;
    arm_cyc = 1 << 30;
    #1;
    check("reset_async_mid", outs, 11'b0);
    @(posedge clk);
    #1;
    check("reset_mid_held", outs, 11'b0);
    release_reset();

    // Random opcodes.
    for (int i = 0; i < 1000; i++) begin
      r = 4'($urandom_range(0, 15));
      issue(r);
    end
    drain();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish, expected completion");
    $fatal(1, "timeout");
  end

endmodule
